dram_arbiter: RTL

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// Two-master (68000 CPU / DMA) arbiter in front of a single DRAM controller port.
// Alternating priority on ties, per-cycle watchdog, registered outputs, synchronous active-low reset.
module dram_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_CS,
  input  logic        CPU_AS,
  input  logic        CPU_LDS,
  input  logic        CPU_UDS,
  input  logic        CPU_RW,
  input  logic [23:1] CPU_ADDR,
  output logic        CPU_DTACK,
  output logic        CPU_BERR,
  input  logic        DMA_REQ,
  input  logic        DMA_RW,
  input  logic        DMA_LDS,
  input  logic        DMA_UDS,
  input  logic [23:1] DMA_ADDR,
  output logic        DMA_ACK,
  output logic        DMA_ERR,
  output logic        M_CS,
  output logic        M_AS,
  output logic        M_LDS,
  output logic        M_UDS,
  output logic        M_RW,
  output logic [23:1] M_ADDR,
  input  logic        M_DTACK
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    CPU_RUN,
    CPU_HOLD,
    DMA_RUN,
    RECOVER
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_wd, w_wd;
  logic          r_last_dma, w_last_dma;
  logic          r_m_cs, w_m_cs;
  logic          r_m_as, w_m_as;
  logic          r_m_lds, w_m_lds;
  logic          r_m_uds, w_m_uds;
  logic          r_m_rw, w_m_rw;
  logic [23:1]   r_m_addr, w_m_addr;
  logic          r_cpu_dtack, w_cpu_dtack;
  logic          r_cpu_berr, w_cpu_berr;
  logic          r_dma_ack, w_dma_ack;
  logic          r_dma_err, w_dma_err;

  logic          w_cpu_req;
  logic          w_dma_req;
  logic          w_wd_done;
  logic [CW-1:0] w_wd_inc;

  assign w_cpu_req = !CPU_CS && !CPU_AS;
  assign w_dma_req = DMA_REQ;
  assign w_wd_done = (r_wd == WD_MAX);
  assign w_wd_inc  = w_wd_done ? r_wd : r_wd + CW'(1);

  always_comb begin
    w_state     = r_state;
    w_wd        = r_wd;
    w_last_dma  = r_last_dma;
    w_m_cs      = r_m_cs;
    w_m_as      = r_m_as;
    w_m_lds     = r_m_lds;
    w_m_uds     = r_m_uds;
    w_m_rw      = r_m_rw;
    w_m_addr    = r_m_addr;
    w_cpu_dtack = r_cpu_dtack;
    w_cpu_berr  = r_cpu_berr;
    w_dma_ack   = 1'b0;
    w_dma_err   = 1'b0;

    case (r_state)
      IDLE: begin
        // On a tie the master that did not win last time gets the bus.
        if (w_cpu_req && (!w_dma_req || r_last_dma)) begin
          w_state    = CPU_RUN;
          w_last_dma = 1'b0;
          w_wd       = '0;
          w_m_cs     = 1'b0;
          w_m_as     = 1'b0;
          w_m_addr   = CPU_ADDR;
          w_m_rw     = CPU_RW;
          w_m_lds    = CPU_LDS;
          w_m_uds    = CPU_UDS;
        end else if (w_dma_req) begin
          w_state    = DMA_RUN;
          w_last_dma = 1'b1;
          w_wd       = '0;
          w_m_cs     = 1'b0;
          w_m_as     = 1'b0;
          w_m_addr   = DMA_ADDR;
          w_m_rw     = DMA_RW;
          w_m_lds    = DMA_LDS;
          w_m_uds    = DMA_UDS;
        end
      end

      CPU_RUN: begin
        if (CPU_AS) begin
          w_state = RECOVER;
          w_m_cs  = 1'b1;
          w_m_as  = 1'b1;
        end else if (!M_DTACK) begin
          w_state     = CPU_HOLD;
          w_cpu_dtack = 1'b0;
        end else if (w_wd_done) begin
          // Bus error is held in CPU_HOLD until the CPU drops its strobe.
          w_state    = CPU_HOLD;
          w_cpu_berr = 1'b0;
          w_m_cs     = 1'b1;
          w_m_as     = 1'b1;
        end else begin
          w_wd = w_wd_inc;
        end
      end

      CPU_HOLD: begin
        if (CPU_AS) begin
          w_state     = RECOVER;
          w_cpu_dtack = 1'b1;
          w_cpu_berr  = 1'b1;
          w_m_cs      = 1'b1;
          w_m_as      = 1'b1;
        end
      end

      DMA_RUN: begin
        if (!M_DTACK) begin
          w_state   = RECOVER;
          w_dma_ack = 1'b1;
          w_m_cs    = 1'b1;
          w_m_as    = 1'b1;
        end else if (w_wd_done) begin
          w_state   = RECOVER;
          w_dma_err = 1'b1;
          w_m_cs    = 1'b1;
          w_m_as    = 1'b1;
        end else begin
          w_wd = w_wd_inc;
        end
      end

      RECOVER: begin
        if (M_DTACK) w_state = IDLE;
      end

      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_wd        <= '0;
      r_last_dma  <= 1'b1;
      r_m_cs      <= 1'b1;
      r_m_as      <= 1'b1;
      r_m_lds     <= 1'b1;
      r_m_uds     <= 1'b1;
      r_m_rw      <= 1'b1;
      r_m_addr    <= '0;
      r_cpu_dtack <= 1'b1;
      r_cpu_berr  <= 1'b1;
      r_dma_ack   <= 1'b0;
      r_dma_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_wd        <= w_wd;
      r_last_dma  <= w_last_dma;
      r_m_cs      <= w_m_cs;
      r_m_as      <= w_m_as;
      r_m_lds     <= w_m_lds;
      r_m_uds     <= w_m_uds;
      r_m_rw      <= w_m_rw;
      r_m_addr    <= w_m_addr;
      r_cpu_dtack <= w_cpu_dtack;
      r_cpu_berr  <= w_cpu_berr;
      r_dma_ack   <= w_dma_ack;
      r_dma_err   <= w_dma_err;
    end
  end

  assign M_CS      = r_m_cs;
  assign M_AS      = r_m_as;
  assign M_LDS     = r_m_lds;
  assign M_UDS     = r_m_uds;
  assign M_RW      = r_m_rw;
  assign M_ADDR    = r_m_addr;
  assign CPU_DTACK = r_cpu_dtack;
  assign CPU_BERR  = r_cpu_berr;
  assign DMA_ACK   = r_dma_ack;
  assign DMA_ERR   = r_dma_err;

endmodule
